// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: programmable raster timing, framebuffer address
// generation with power-of-two pixel replication, palette / RGB332 colour
// conversion, and sync/blank delay lines aligned with the pixel pipeline.
module vga_fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SCALE      = 0,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iMODE,
    input  logic              iPAL_WE,
    input  logic [7:0]        iPAL_ADDR,
    input  logic [23:0]       iPAL_DATA,
    output logic [ADDR_W-1:0] oFB_ADDR,
    input  logic [7:0]        iFB_DATA,
    output logic              oFRAME,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        oR,
    output logic [7:0]        oG,
    output logic [7:0]        oB
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int L       = RD_LATENCY + 2;

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]     H_MASK   = HW'((1 << SCALE) - 1);
    localparam logic [VW-1:0]     V_MASK   = VW'((1 << SCALE) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE);

    // Raster position; run_q is low until the first clock after reset, which
    // loads position (0,0) without advancing so oFRAME pulses right away.
    logic [HW-1:0]     h_cnt, h_nxt;
    logic [VW-1:0]     v_cnt, v_nxt;
    logic              run_q;
    logic              sof, act_nxt, hs_nxt, vs_nxt;

    logic [ADDR_W-1:0] row_base, col_addr;
    logic [ADDR_W-1:0] base_c, col_c, row_nxt, col_nxt, addr_nxt;
    logic [ADDR_W-1:0] fb_addr_q;
    logic              frame_q;
    logic              mode_q;

    // Index 0 holds the value for the current counter cycle, index L drives the pin.
    logic [L:0]        hs_dl, vs_dl, blank_dl;

    logic [23:0]       pal [256];
    logic [23:0]       pix_p1;
    logic [7:0]        r_p2, g_p2, b_p2;

    function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
        logic [2:0] r3, g3;
        logic [1:0] b2;
        r3 = d[7:5];
        g3 = d[4:2];
        b2 = d[1:0];
        return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
    endfunction

    // Next raster position, raw timing and incremental framebuffer address.
    always_comb begin
        h_nxt = h_cnt + HW'(1);
        v_nxt = v_cnt;
        if (!run_q) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end

        sof     = (h_nxt == '0) && (v_nxt == '0);
        act_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        hs_nxt  = (int'(h_nxt) >= H_ACTIVE + H_FP &&
                   int'(h_nxt) <  H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
        vs_nxt  = (int'(v_nxt) >= V_ACTIVE + V_FP &&
                   int'(v_nxt) <  V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;

        base_c   = sof ? '0 : row_base;
        col_c    = sof ? '0 : col_addr;
        row_nxt  = base_c;
        col_nxt  = col_c;
        addr_nxt = fb_addr_q;
        if (act_nxt) begin
            addr_nxt = col_c;
            if (int'(h_nxt) == H_ACTIVE - 1) begin
                if ((v_nxt & V_MASK) == V_MASK) begin
                    row_nxt = base_c + ROW_STEP;
                end
                col_nxt = row_nxt;
            end else if ((h_nxt & H_MASK) == H_MASK) begin
                col_nxt = col_c + ADDR_W'(1);
            end
        end
    end

    // Control state: counters, address, frame pulse, mode latch, delay lines.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            run_q     <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            row_base  <= '0;
            col_addr  <= '0;
            fb_addr_q <= '0;
            frame_q   <= 1'b0;
            mode_q    <= 1'b0;
            hs_dl     <= {(L+1){~HS_POL}};
            vs_dl     <= {(L+1){~VS_POL}};
            blank_dl  <= '0;
        end else begin
            run_q     <= 1'b1;
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            row_base  <= row_nxt;
            col_addr  <= col_nxt;
            fb_addr_q <= addr_nxt;
            frame_q   <= sof;
            if (frame_q) begin
                mode_q <= iMODE;
            end
            hs_dl     <= {hs_dl[L-1:0], hs_nxt};
            vs_dl     <= {vs_dl[L-1:0], vs_nxt};
            blank_dl  <= {blank_dl[L-1:0], act_nxt};
        end
    end

    // Palette write port and colour lookup stage (read-before-write on collision).
    always_ff @(posedge iVGA_CLK) begin
        if (iPAL_WE) begin
            pal[iPAL_ADDR] <= iPAL_DATA;
        end
        pix_p1 <= mode_q ? expand_rgb332(iFB_DATA) : pal[iFB_DATA];
    end

    // Output register: colour forced to black outside the visible region.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_p2 <= '0;
            g_p2 <= '0;
            b_p2 <= '0;
        end else if (blank_dl[L-1]) begin
            r_p2 <= pix_p1[23:16];
            g_p2 <= pix_p1[15:8];
            b_p2 <= pix_p1[7:0];
        end else begin
            r_p2 <= '0;
            g_p2 <= '0;
            b_p2 <= '0;
        end
    end

    assign oFB_ADDR = fb_addr_q;
    assign oFRAME   = frame_q;
    assign oHS      = hs_dl[L];
    assign oVS      = vs_dl[L];
    assign oBLANK_n = blank_dl[L];
    assign oR       = r_p2;
    assign oG       = g_p2;
    assign oB       = b_p2;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a 14x7 raster, with a second
// instance at SCALE=1 to exercise pixel replication addressing.
module tb_vga_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b1;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = 8'd0;
    logic [23:0] pal_data = 24'd0;

    logic [18:0] addr0, addr1;
    logic [7:0]  fb0 = 8'd0, fb1 = 8'd0;
    logic        frame0, hs0, vs0, bl0;
    logic        frame1, hs1, vs1, bl1;
    logic [7:0]  r0, g0, b0, r1, g1, b1;

    logic [7:0]  fb_xor = 8'd0;
    logic        fb_force = 1'b0;

    int checks = 0;
    int passes = 0;
    int exp_a = 0;
    int exp_as = 0;
    logic [23:0] exp_vis = 24'h123456;
    int n_bl = 0, n_vs = 0, n_hs = 0;

    always #5 clk = ~clk;

    // Synchronous framebuffer models, one-cycle read latency.
    always @(posedge clk) begin
        fb0 <= fb_force ? 8'd5 : (addr0[7:0] ^ fb_xor);
        fb1 <= addr1[7:0];
    end

    vga_fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(0), .RD_LATENCY(1), .ADDR_W(19)
    ) u_dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMODE(mode),
        .iPAL_WE(pal_we), .iPAL_ADDR(pal_addr), .iPAL_DATA(pal_data),
        .oFB_ADDR(addr0), .iFB_DATA(fb0), .oFRAME(frame0),
        .oHS(hs0), .oVS(vs0), .oBLANK_n(bl0), .oR(r0), .oG(g0), .oB(b0)
    );

    vga_fb_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(1), .RD_LATENCY(1), .ADDR_W(19)
    ) u_dut_s (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMODE(mode),
        .iPAL_WE(pal_we), .iPAL_ADDR(pal_addr), .iPAL_DATA(pal_data),
        .oFB_ADDR(addr1), .iFB_DATA(fb1), .oFRAME(frame1),
        .oHS(hs1), .oVS(vs1), .oBLANK_n(bl1), .oR(r1), .oG(g1), .oB(b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hs"},    32'(hs0), 32'd1);
        chk({tag, "_vs"},    32'(vs0), 32'd1);
        chk({tag, "_blank"}, 32'(bl0), 32'd0);
        chk({tag, "_rgb"},   32'({r0, g0, b0}), 32'd0);
        chk({tag, "_addr"},  32'(addr0), 32'd0);
        chk({tag, "_frame"}, 32'(frame0), 32'd0);
        chk({tag, "_addr_s"}, 32'(addr1), 32'd0);
    endtask

    // Per-cycle raster checks; t counts cycles from the first oFRAME after reset.
    task automatic check_cycle(input int t, input int pal_from);
        int h, v, hp, vp, pf;
        logic ehs, evs, ebl;
        h  = t % 14;
        v  = (t / 14) % 7;
        hp = (t - 3) % 14;
        vp = ((t - 3) / 14) % 7;
        pf = (t - 3) / 98;
        ehs = !(t >= 3 && hp >= 10 && hp < 12);
        evs = !(t >= 3 && vp == 5);
        ebl = (t >= 3 && hp < 8 && vp < 4);
        chk("frame",   32'(frame0), 32'(t % 98 == 0));
        chk("frame_s", 32'(frame1), 32'(t % 98 == 0));
        chk("hs",      32'(hs0), 32'(ehs));
        chk("vs",      32'(vs0), 32'(evs));
        chk("blank",   32'(bl0), 32'(ebl));
        chk("hs_s",    32'(hs1), 32'(ehs));
        chk("blank_s", 32'(bl1), 32'(ebl));
        if (!ebl) chk("blank_rgb", 32'({r0, g0, b0}), 32'd0);
        else if (pf >= pal_from) chk("pal_rgb", 32'({r0, g0, b0}), 32'(exp_vis));
        if (h < 8 && v < 4) begin
            exp_a  = h + v * 8;
            exp_as = (h >> 1) + (v >> 1) * 4;
        end
        chk("addr",   32'(addr0), 32'(exp_a));
        chk("addr_s", 32'(addr1), 32'(exp_as));
        if (t >= 3 && t < 101) begin
            if (bl0) n_bl++;
            if (!vs0) n_vs++;
            if (!hs0) n_hs++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 425; t++) begin
            if (t == 90)  fb_xor = 8'hE0;
            if (t == 115) mode = 1'b0;
            if (t == 150) begin
                pal_we = 1'b1; pal_addr = 8'd5; pal_data = 24'h123456; fb_force = 1'b1;
            end
            if (t == 151) pal_we = 1'b0;
            if (t == 313) begin
                pal_we = 1'b1; pal_addr = 8'd5; pal_data = 24'hABCDEF;
            end
            if (t == 314) pal_we = 1'b0;
            if (t == 316) exp_vis = 24'hABCDEF;

            check_cycle(t, 2);

            if (t == 6)   chk("direct_addr03", 32'({r0, g0, b0}), 32'h0000FF);
            if (t == 10)  chk("direct_addr07", 32'({r0, g0, b0}), 32'h0024FF);
            if (t == 50)  chk("direct_addr1d", 32'({r0, g0, b0}), 32'h00FF55);
            if (t == 101) chk("direct_dataE0", 32'({r0, g0, b0}), 32'hFF0000);
            if (t == 120) chk("mode_hold_ED",  32'({r0, g0, b0}), 32'hFF6D55);
            if (t == 143) chk("mode_hold_F8",  32'({r0, g0, b0}), 32'hFFDB00);
            if (t == 199) chk("mode_next_frame", 32'({r0, g0, b0}), 32'h123456);
            if (t == 315) chk("pal_collide_old", 32'({r0, g0, b0}), 32'h123456);
            if (t == 316) chk("pal_collide_new", 32'({r0, g0, b0}), 32'hABCDEF);

            @(posedge clk);
            #1;
        end

        chk("frame0_blank_cycles", 32'(n_bl), 32'd32);
        chk("frame0_vs_cycles",    32'(n_vs), 32'd14);
        chk("frame0_hs_cycles",    32'(n_hs), 32'd14);

        // Mid-frame reset at v=2, h=5 of the fifth frame.
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_reset("mid_rst_hold");
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        exp_a = 0;
        exp_as = 0;
        n_bl = 0;
        n_vs = 0;
        n_hs = 0;
        for (int t = 0; t < 200; t++) begin
            check_cycle(t, 0);
            @(posedge clk);
            #1;
        end
        chk("restart_blank_cycles", 32'(n_bl), 32'd32);
        chk("restart_vs_cycles",    32'(n_vs), 32'd14);
        chk("restart_hs_cycles",    32'(n_hs), 32'd14);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
